// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin arbiter that serialises push/pop requests from
// NUM_REQ requesters onto one shared stack. Each accepted op walks through
// IDLE (grant) -> ISSUE (stack strobe) -> RESP (completion pulse).
module stack_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          stk_push,
  output logic                          stk_pop,
  output logic [DATA_WIDTH-1:0]         stk_data_in,
  input  logic [DATA_WIDTH-1:0]         stk_data_out,
  input  logic                          stk_full,
  input  logic                          stk_empty
);

  localparam int   IDW    = $clog2(NUM_REQ);
  localparam logic OP_POP = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [IDW-1:0]        last_grant_r;
  logic [IDW-1:0]        win_id_r;
  logic                  win_op_r;
  logic [DATA_WIDTH-1:0] win_data_r;
  logic                  err_r;
  logic                  issue_err_s;
  logic                  grant_found_s;
  logic [IDW-1:0]        grant_id_s;
  logic [IDW-1:0]        cand_s;
  logic [DATA_WIDTH-1:0] req_word_s [NUM_REQ];

  // Split the flat request data bus into one word per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_word_s[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    cand_s        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = IDW'((int'(last_grant_r) + k) % NUM_REQ);
      if (!grant_found_s && req_valid[cand_s]) begin
        grant_found_s = 1'b1;
        grant_id_s    = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Next-state logic plus grant and stack strobes; reset forces all quiet.
  always_comb begin
    state_s     = state_r;
    req_ready   = '0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_data_in = '0;
    issue_err_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_found_s) begin
          state_s               = ISSUE;
          req_ready[grant_id_s] = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        state_s = RESP;
        if (win_op_r == OP_POP) begin
          if (!stk_empty) begin
            stk_pop = 1'b1;
          end else begin
            issue_err_s = 1'b1;
          end
        end else begin
          if (!stk_full) begin
            stk_push    = 1'b1;
            stk_data_in = win_data_r;
          end else begin
            issue_err_s = 1'b1;
          end
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (reset) begin
      state_s     = IDLE;
      req_ready   = '0;
      stk_push    = 1'b0;
      stk_pop     = 1'b0;
      stk_data_in = '0;
    end else begin
      state_s = state_s;
    end
  end

  // Completion pulse in RESP; popped data only for a successful pop.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    if (!reset && (state_r == RESP)) begin
      rsp_valid = 1'b1;
      rsp_id    = win_id_r;
      rsp_err   = err_r;
      if ((win_op_r == OP_POP) && !err_r) begin
        rsp_data = stk_data_out;
      end else begin
        rsp_data = '0;
      end
    end else begin
      rsp_valid = 1'b0;
    end
  end

  // State, round-robin pointer, accepted op and error flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      last_grant_r <= IDW'(NUM_REQ - 1);
      win_id_r     <= '0;
      win_op_r     <= 1'b0;
      win_data_r   <= '0;
      err_r        <= 1'b0;
    end else begin
      state_r <= state_s;
      if ((state_r == IDLE) && grant_found_s) begin
        last_grant_r <= grant_id_s;
        win_id_r     <= grant_id_s;
        win_op_r     <= req_op[grant_id_s];
        win_data_r   <= req_word_s[grant_id_s];
      end
      if (state_r == ISSUE) begin
        err_r <= issue_err_s;
      end
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboard bench for stack_arbiter: stimulus queues expected grants,
// strobes and responses; a negedge monitor checks them with fixed latency.
module tb_stack_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_op = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_data;
  logic              rsp_err;
  logic              stk_push;
  logic              stk_pop;
  logic [DW-1:0]     stk_data_in;
  logic [DW-1:0]     stk_data_out;
  logic              stk_full;
  logic              stk_empty;

  logic              stk_reset = 1'b1;
  logic              force_full = 1'b0;
  logic [DW-1:0]     sb_mem [DEPTH];
  int                sb_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    bit          push;
    bit          pop;
    logic [7:0]  sdata;
    bit          err;
    logic [7:0]  rdata;
  } exp_t;

  exp_t exp_q [$];

  stack_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
    .stk_data_out(stk_data_out), .stk_full(stk_full), .stk_empty(stk_empty)
  );

  always #5 clk = ~clk;

  assign stk_full  = force_full || (sb_cnt == DEPTH);
  assign stk_empty = (sb_cnt == 0);

  // Behavioural LIFO with registered read data.
  always @(posedge clk) begin
    if (stk_reset) begin
      sb_cnt       <= 0;
      stk_data_out <= '0;
    end else if (stk_push && (sb_cnt < DEPTH)) begin
      sb_mem[sb_cnt] <= stk_data_in;
      sb_cnt         <= sb_cnt + 1;
    end else if (stk_pop && (sb_cnt > 0)) begin
      stk_data_out <= sb_mem[sb_cnt-1];
      sb_cnt       <= sb_cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: grant at T, strobe check at T+1, response check at T+2.
  initial begin : monitor
    exp_t s1, s2;
    bit   s1_v, s2_v;
    int   gid;
    s1_v = 1'b0;
    s2_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp", {26'd0, rsp_valid, rsp_err, 2'(rsp_id), 2'd0}, 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_strobes", {22'd0, stk_push, stk_pop, stk_data_in}, 32'd0);
        s1_v = 1'b0;
        s2_v = 1'b0;
      end else begin
        chk("protocol", 32'((stk_push && stk_pop) || ($countones(req_ready) > 1)), 32'd0);
        if (s2_v) begin
          chk("rsp_valid", 32'(rsp_valid), 32'd1);
          chk("rsp_id", 32'(rsp_id), 32'(s2.id));
          chk("rsp_err", 32'(rsp_err), 32'(s2.err));
          chk("rsp_data", 32'(rsp_data), 32'(s2.rdata));
        end else begin
          chk("no_rsp", 32'(rsp_valid), 32'd0);
        end
        if (s1_v) begin
          chk("stk_push", 32'(stk_push), 32'(s1.push));
          chk("stk_pop", 32'(stk_pop), 32'(s1.pop));
          chk("stk_data_in", 32'(stk_data_in), 32'(s1.sdata));
        end else begin
          chk("no_strobe", {30'd0, stk_push, stk_pop}, 32'd0);
        end
        s2   = s1;
        s2_v = s1_v;
        s1_v = 1'b0;
        if (req_ready != '0) begin
          gid = -1;
          for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) gid = i;
          end
          if (exp_q.size() == 0) begin
            chk("unexpected_grant", 32'(gid), 32'hFFFF_FFFF);
          end else begin
            s1 = exp_q.pop_front();
            chk("grant_id", 32'(gid), 32'(s1.id));
            s1_v = 1'b1;
          end
        end
      end
    end
  end

  function automatic exp_t mk(input int id, input bit op, input logic [7:0] d,
                              input bit err, input logic [7:0] rd);
    exp_t e;
    e.id    = id;
    e.push  = !op && !err;
    e.pop   = op && !err;
    e.sdata = (!op && !err) ? d : 8'h00;
    e.err   = err;
    e.rdata = rd;
    return e;
  endfunction

  // Single op from one requester: hold until accepted, then drain the pipeline.
  task automatic do_op(input int id, input bit op, input logic [7:0] d,
                       input bit err, input logic [7:0] rd);
    int cyc;
    exp_q.push_back(mk(id, op, d, err, rd));
    @(posedge clk); #1;
    req_valid[id]        = 1'b1;
    req_op[id]           = op;
    req_data[id*DW +: DW] = d;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!req_ready[id] && (cyc < 20));
    if (!req_ready[id]) chk("grant_timeout", 32'(id), 32'hFFFF_FFFF);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset     = 1'b1;
    stk_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    stk_reset = 1'b0;
  endtask

  initial begin : stimulus
    int cyc;
    // Reset with requests pending: grants must stay forced low.
    req_valid = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    reset     = 1'b0;
    stk_reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single push, push-then-pop, pop back the first word.
    do_op(2, 1'b0, 8'hA5, 1'b0, 8'h00);
    do_op(0, 1'b0, 8'h3C, 1'b0, 8'h00);
    do_op(1, 1'b1, 8'h00, 1'b0, 8'h3C);
    do_op(3, 1'b1, 8'h00, 1'b0, 8'hA5);
    // Boundaries: pop while empty, push while full.
    do_op(1, 1'b1, 8'h00, 1'b1, 8'h00);
    force_full = 1'b1;
    do_op(0, 1'b0, 8'h77, 1'b1, 8'h00);
    force_full = 1'b0;

    // Round-robin fairness with all requesters holding requests.
    do_reset();
    exp_q.push_back(mk(0, 1'b0, 8'h10, 1'b0, 8'h00));
    exp_q.push_back(mk(1, 1'b0, 8'h11, 1'b0, 8'h00));
    exp_q.push_back(mk(2, 1'b0, 8'h12, 1'b0, 8'h00));
    exp_q.push_back(mk(3, 1'b0, 8'h13, 1'b0, 8'h00));
    exp_q.push_back(mk(0, 1'b0, 8'h10, 1'b0, 8'h00));
    req_op    = '0;
    req_data  = 32'h1312_1110;
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while ((req_ready == '0) && (cyc < 20));
      chk("rr_interval", 32'(cyc), (g == 0) ? 32'd1 : 32'd3);
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(negedge clk);

    // Reset in the ISSUE cycle of a pop aborts it; requester 0 wins next.
    exp_q.push_back(mk(2, 1'b1, 8'h00, 1'b0, 8'h00));
    @(posedge clk); #1;
    req_valid[2] = 1'b1;
    req_op[2]    = 1'b1;
    @(negedge clk);
    chk("abort_grant", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    reset        = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.push_back(mk(0, 1'b0, 8'h55, 1'b0, 8'h00));
    exp_q.push_back(mk(2, 1'b0, 8'h66, 1'b0, 8'h00));
    req_op       = '0;
    req_data     = 32'h0066_0055;
    req_valid    = 4'b0101;
    @(negedge clk);
    chk("post_reset_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!req_ready[2] && (cyc < 20));
    chk("second_grant_interval", 32'(cyc), 32'd3);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(negedge clk);
    chk("stack_depth", 32'(sb_cnt), 32'd7);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
